// File: rtl/timer_ctrl.sv
// Timer control stage for the free-running count block: prescaled tick,
// compare match, counter clear and level interrupt behind a 4-register port.
module timer_ctrl #(
    parameter int unsigned WIDTH     = 12,
    parameter int unsigned PSC_WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             we_i,
    input  logic [1:0]       addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    input  logic [WIDTH-1:0] count_i,
    output logic             tick_o,
    output logic             clr_o,
    output logic             irq_o
);

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PSC    = 2'd1;
    localparam logic [1:0] ADDR_CMP    = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    logic                 ctrl_en;
    logic                 ctrl_per;
    logic                 ctrl_ie;
    logic [PSC_WIDTH-1:0] psc;
    logic [WIDTH-1:0]     cmp;
    logic                 pend;
    logic [PSC_WIDTH-1:0] psc_cnt;

    logic ctrl_wr;
    logic psc_wr;
    logic cmp_wr;
    logic status_wr;
    logic match;

    // Write decode, tick/match/clear generation and read mux
    always_comb begin
        ctrl_wr   = we_i && (addr_i == ADDR_CTRL);
        psc_wr    = we_i && (addr_i == ADDR_PSC);
        cmp_wr    = we_i && (addr_i == ADDR_CMP);
        status_wr = we_i && (addr_i == ADDR_STATUS);

        tick_o = ctrl_en && (psc_cnt == psc);
        match  = tick_o && (count_i == cmp);
        clr_o  = (match && ctrl_per) || (ctrl_wr && wdata_i[3]);
        irq_o  = pend && ctrl_ie;

        rdata_o = '0;
        case (addr_i)
            ADDR_CTRL:   rdata_o = WIDTH'({ctrl_ie, ctrl_per, ctrl_en});
            ADDR_PSC:    rdata_o = WIDTH'(psc);
            ADDR_CMP:    rdata_o = cmp;
            ADDR_STATUS: rdata_o = WIDTH'(pend);
            default:     rdata_o = '0;
        endcase
    end

    // Control register; a CTRL write overrides the one-shot auto-stop
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ctrl_en  <= 1'b0;
            ctrl_per <= 1'b0;
            ctrl_ie  <= 1'b0;
        end else if (ctrl_wr) begin
            ctrl_en  <= wdata_i[0];
            ctrl_per <= wdata_i[1];
            ctrl_ie  <= wdata_i[2];
        end else if (match && !ctrl_per) begin
            ctrl_en  <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            psc <= '0;
            cmp <= '0;
        end else begin
            if (psc_wr) psc <= wdata_i[PSC_WIDTH-1:0];
            if (cmp_wr) cmp <= wdata_i;
        end
    end

    // Pending flag: a match in the same cycle beats the W1C
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend <= 1'b0;
        end else if (match) begin
            pend <= 1'b1;
        end else if (status_wr && wdata_i[0]) begin
            pend <= 1'b0;
        end
    end

    // Prescaler: restarts on a PSC write or an EN 0->1 write, holds while stopped
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            psc_cnt <= '0;
        end else if (psc_wr) begin
            psc_cnt <= '0;
        end else if (ctrl_wr && wdata_i[0] && !ctrl_en) begin
            psc_cnt <= '0;
        end else if (ctrl_en) begin
            psc_cnt <= tick_o ? '0 : psc_cnt + PSC_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed self-checking bench for timer_ctrl with a behavioural model of the
// downstream count block closing the tick/clear loop.
module tb_timer_ctrl;

    localparam int unsigned WIDTH     = 12;
    localparam int unsigned PSC_WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             we;
    logic [1:0]       addr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rdata;
    logic [WIDTH-1:0] count;
    logic             tick;
    logic             clr;
    logic             irq;

    int tests_run = 0;
    int tests_failed = 0;

    timer_ctrl #(.WIDTH(WIDTH), .PSC_WIDTH(PSC_WIDTH)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .we_i    (we),
        .addr_i  (addr),
        .wdata_i (wdata),
        .rdata_o (rdata),
        .count_i (count),
        .tick_o  (tick),
        .clr_o   (clr),
        .irq_o   (irq)
    );

    always #5 clk = ~clk;

    // Model of the external count block: synchronous clear, enable-gated increment
    always @(posedge clk or posedge rst) begin
        if (rst)       count <= '0;
        else if (clr)  count <= '0;
        else if (tick) count <= count + WIDTH'(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [WIDTH-1:0] d);
        we = 1'b1; addr = a; wdata = d;
        step();
        we = 1'b0;
    endtask

    // RESTART write with EN/PER/IE cleared; clr must pulse in the write cycle
    task automatic restart();
        we = 1'b1; addr = 2'd0; wdata = WIDTH'(8);
        #1;
        check("restart_clr", 32'(clr), 32'd1);
        @(posedge clk);
        #1;
        we = 1'b0;
        check("restart_count", 32'(count), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst = 1'b1; we = 1'b0; addr = 2'd0; wdata = '0;
        #1;
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_clr", 32'(clr), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        step();
        step();
        rst = 1'b0;

        // Basic tick: PSC=3 -> one tick every 4 cycles
        wr(2'd1, WIDTH'(3));
        wr(2'd2, WIDTH'(12'hFFF));
        wr(2'd0, WIDTH'(1));
        for (int i = 0; i < 12; i++) begin
            check("basic_tick", 32'(tick), 32'((i % 4) == 3));
            check("basic_count", 32'(count), 32'(i / 4));
            check("basic_irq", 32'(irq), 32'd0);
            step();
        end
        restart();

        // Periodic: PSC=0, CMP=5
        wr(2'd1, WIDTH'(0));
        wr(2'd2, WIDTH'(5));
        wr(2'd0, WIDTH'(7));
        for (int i = 0; i < 14; i++) begin
            check("per_count", 32'(count), 32'(i % 6));
            check("per_clr", 32'(clr), 32'((i % 6) == 5));
            check("per_irq", 32'(irq), 32'(i >= 6));
            step();
        end
        wr(2'd3, WIDTH'(1));
        check("per_w1c_irq", 32'(irq), 32'd0);
        step();
        step();
        check("coll_clr", 32'(clr), 32'd1);
        check("coll_count", 32'(count), 32'd5);
        wr(2'd3, WIDTH'(1));
        check("coll_irq", 32'(irq), 32'd1);
        check("coll_pend", 32'(rdata), 32'd1);
        wr(2'd3, WIDTH'(1));
        check("coll_w1c_irq", 32'(irq), 32'd0);
        check("coll_w1c_pend", 32'(rdata), 32'd0);
        restart();

        // One-shot: PSC=1, CMP=2
        wr(2'd1, WIDTH'(1));
        wr(2'd2, WIDTH'(2));
        wr(2'd0, WIDTH'(5));
        for (int i = 0; i < 10; i++) begin
            check("os_tick", 32'(tick), 32'((i <= 5) && ((i % 2) == 1)));
            check("os_clr", 32'(clr), 32'd0);
            check("os_count", 32'(count), 32'((i < 6) ? (i / 2) : 3));
            check("os_irq", 32'(irq), 32'(i >= 6));
            step();
        end
        addr = 2'd0;
        #1;
        check("os_ctrl", 32'(rdata), 32'd4);
        wr(2'd3, WIDTH'(1));
        check("os_w1c_irq", 32'(irq), 32'd0);
        restart();

        // Wrap: count reaches 10 with CMP=4, match after 4090 ticks
        wr(2'd1, WIDTH'(0));
        wr(2'd2, WIDTH'(12'hFFF));
        wr(2'd0, WIDTH'(7));
        for (int i = 0; i < 9; i++) step();
        check("wrap_pre", 32'(count), 32'd9);
        wr(2'd2, WIDTH'(4));
        check("wrap_start", 32'(count), 32'd10);
        n = 0;
        while (!clr && n < 5000) begin
            step();
            n++;
        end
        check("wrap_ticks", 32'(n), 32'd4090);
        check("wrap_count", 32'(count), 32'd4);
        step();
        check("wrap_irq", 32'(irq), 32'd1);
        check("wrap_cleared", 32'(count), 32'd0);

        // Async reset mid-cycle during periodic operation
        addr = 2'd0;
        #3;
        rst = 1'b1;
        #1;
        check("arst_tick", 32'(tick), 32'd0);
        check("arst_clr", 32'(clr), 32'd0);
        check("arst_irq", 32'(irq), 32'd0);
        check("arst_rdata", 32'(rdata), 32'd0);
        step();
        rst = 1'b0;
        for (int a = 0; a < 4; a++) begin
            addr = 2'(a);
            #1;
            check("arst_reg", 32'(rdata), 32'd0);
        end
        step();
        check("arst_tick_after", 32'(tick), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
